// File: rtl/cdb_arb.sv
// ---------------------------------------------------------------------------
// cdb_arb -- common-data-bus writeback arbiter
//
// Collects active-low writeback requests from UNITS execution units. Each
// cycle it grants up to PORTS of them in round-robin order, starting the scan
// at ptr. The k-th unit found goes to port k. Grants are acknowledged
// combinationally on wb_ack_. The granted payloads are registered onto the
// broadcast ports on the next rising edge.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   wb_req_   [UNITS]     active-low writeback request per unit
//   wb_data/rd/tag        per-unit payload, unit u in slice u
//   wb_ack_   [UNITS]     active-low grant, combinational
//   cdb_stall             consumer busy: no grants, broadcast regs hold
//   flush                 discard registered broadcasts, no grants
//   cdb_valid [PORTS]     registered broadcast valid per port
//   cdb_data/rd/tag       registered broadcast payload per port
// ---------------------------------------------------------------------------
module cdb_arb #(
   parameter int DATA  = 32,
   parameter int UNITS = 6,
   parameter int PORTS = 2,
   parameter int REG   = 6,
   parameter int TAG   = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [UNITS-1:0]       wb_req_,
   input  logic [UNITS*DATA-1:0]  wb_data,
   input  logic [UNITS*REG-1:0]   wb_rd,
   input  logic [UNITS*TAG-1:0]   wb_tag,
   output logic [UNITS-1:0]       wb_ack_,
   input  logic                   cdb_stall,
   input  logic                   flush,
   output logic [PORTS-1:0]       cdb_valid,
   output logic [PORTS*DATA-1:0]  cdb_data,
   output logic [PORTS*REG-1:0]   cdb_rd,
   output logic [PORTS*TAG-1:0]   cdb_tag
);

   localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;
   localparam int CW = $clog2(PORTS + 1);

   logic [PW-1:0]         ptr_q, ptr_d;
   logic [PORTS-1:0]      valid_q, valid_d;
   logic [PORTS*DATA-1:0] data_q, data_d;
   logic [PORTS*REG-1:0]  rd_q, rd_d;
   logic [PORTS*TAG-1:0]  tag_q, tag_d;

   logic [UNITS-1:0]      ack_n;
   logic [PORTS-1:0]      port_vld;
   logic [PW-1:0]         port_unit [PORTS];
   logic [PW:0]           scan_sum;
   logic [PW-1:0]         scan_idx;
   logic [CW-1:0]         grant_cnt;

   // Round-robin grant scan. Reset is included so acks stay high while
   // reset is held, independent of the clock.
   always_comb begin
      ack_n     = '1;
      port_vld  = '0;
      for (int k = 0; k < PORTS; k++) begin
         port_unit[k] = '0;
      end
      ptr_d     = ptr_q;
      scan_sum  = '0;
      scan_idx  = '0;
      grant_cnt = '0;
      if (!reset && !flush && !cdb_stall) begin
         for (int i = 0; i < UNITS; i++) begin
            // ptr + i is below 2*UNITS, so one conditional subtract wraps it
            scan_sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(UNITS)) begin
               scan_sum = scan_sum - (PW+1)'(UNITS);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!wb_req_[scan_idx] && (grant_cnt < CW'(PORTS))) begin
               ack_n[scan_idx] = 1'b0;
               for (int k = 0; k < PORTS; k++) begin
                  if (grant_cnt == CW'(k)) begin
                     port_unit[k] = scan_idx;
                     port_vld[k]  = 1'b1;
                  end
               end
               grant_cnt = grant_cnt + CW'(1);
               // The last grant in scan order sets the next start point.
               ptr_d = (scan_idx == PW'(UNITS-1)) ? '0 : scan_idx + PW'(1);
            end
         end
      end
   end

   // Broadcast register next-state. Payload of a port without a grant is
   // left as-is; it is meaningless while that port's valid is low.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      rd_d    = rd_q;
      tag_d   = tag_q;
      if (flush) begin
         valid_d = '0;
      end else if (!cdb_stall) begin
         valid_d = port_vld;
         for (int k = 0; k < PORTS; k++) begin
            for (int u = 0; u < UNITS; u++) begin
               if (port_vld[k] && (port_unit[k] == PW'(u))) begin
                  data_d[k*DATA +: DATA] = wb_data[u*DATA +: DATA];
                  rd_d[k*REG +: REG]     = wb_rd[u*REG +: REG];
                  tag_d[k*TAG +: TAG]    = wb_tag[u*TAG +: TAG];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q   <= '0;
         valid_q <= '0;
         data_q  <= '0;
         rd_q    <= '0;
         tag_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         tag_q   <= tag_d;
      end
   end

   assign wb_ack_   = ack_n;
   assign cdb_valid = valid_q;
   assign cdb_data  = data_q;
   assign cdb_rd    = rd_q;
   assign cdb_tag   = tag_q;

endmodule
